// File: rtl/v4_peak_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : package_settings_v_4
// Description : Shared settings for the v4 shaping chain. Holds the sample
//               width, the pulse-detection levels and timing, and the peak
//               event record passed from the detector into its event queue.
// Revision    : 1.0 - initial release
// ============================================================================
package package_settings_v_4;

    localparam int SIZE_FILTER_DATA = 16;   // signed shaped sample width
    localparam int THRESHOLD_V_4    = 200;  // pulse arms when sample > this
    localparam int HYST_V_4         = 16;   // pulse ends below THRESHOLD - HYST
    localparam int MIN_WIDTH_V_4    = 4;    // shorter pulses are treated as noise
    localparam int HOLDOFF_V_4      = 8;    // dead cycles after a pulse ends
    localparam int TS_WIDTH         = 32;   // timestamp counter width
    localparam int EVT_WIDTH_BITS   = 8;    // saturating pulse-width field

    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0] amp;
        logic [TS_WIDTH-1:0]                ts;
        logic [EVT_WIDTH_BITS-1:0]          width;
    } peak_event_v_4_t;

endpackage
`default_nettype wire

// File: rtl/v4_peak_detector_event_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : v4_event_fifo2
// Description : Two-entry FIFO of peak events with a valid/ready read side.
//               A push is accepted when not full, or when full and a pop
//               happens in the same cycle. The head entry is presented on
//               o_data and stays stable until it is popped.
// Ports       : clk, reset (sync, active-low)
//               i_push/i_data  - write request and event
//               o_full         - both entries occupied
//               o_valid/o_data - head entry present / head entry
//               i_ready        - consumer takes the head this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module v4_event_fifo2
    import package_settings_v_4::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_push,
    input  peak_event_v_4_t i_data,
    output logic            o_full,
    output logic            o_valid,
    input  logic            i_ready,
    output peak_event_v_4_t o_data
);

    peak_event_v_4_t r_mem_q [2];
    peak_event_v_4_t w_mem_d [2];
    logic            r_wr_ptr_q;
    logic            w_wr_ptr_d;
    logic            r_rd_ptr_q;
    logic            w_rd_ptr_d;
    logic [1:0]      r_count_q;
    logic [1:0]      w_count_d;
    logic            w_pop;
    logic            w_push;

    always_comb begin
        w_pop      = (r_count_q != 2'd0) && i_ready;
        // A full queue can still take a write when the head leaves this cycle.
        w_push     = i_push && ((r_count_q != 2'd2) || w_pop);
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_push) begin
            w_mem_d[r_wr_ptr_q] = i_data;
            w_wr_ptr_d          = ~r_wr_ptr_q;
        end
        if (w_pop) begin
            w_rd_ptr_d = ~r_rd_ptr_q;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + 2'd1;
            2'b01:   w_count_d = r_count_q - 2'd1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                r_mem_q[i] <= '0;
            end
            r_wr_ptr_q <= 1'b0;
            r_rd_ptr_q <= 1'b0;
            r_count_q  <= 2'd0;
        end else begin
            r_mem_q    <= w_mem_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    assign o_full  = (r_count_q == 2'd2);
    assign o_valid = (r_count_q != 2'd0);
    assign o_data  = r_mem_q[r_rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/v4_peak_detector.sv
`default_nettype none
// ============================================================================
// Module      : v4_peak_detector
// Description : Watches the shaped sample stream, detects pulses above a
//               threshold with hysteresis, captures the peak amplitude, the
//               timestamp of the peak and the pulse width, and queues one
//               event per qualifying pulse in a 2-entry FIFO.
// Ports       : clk, reset (sync, active-low)
//               filter_data  - signed shaped sample, one per clock
//               event_ready  - consumer accepts the presented event
//               event_valid  - event_amp/ts/width hold a queued event
//               event_amp    - signed peak amplitude
//               event_ts     - timestamp of the peak sample
//               event_width  - above-threshold cycles, saturating at 255
//               drop_count   - events lost to a full queue, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module v4_peak_detector
    import package_settings_v_4::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
    input  logic                               event_ready,
    output logic                               event_valid,
    output logic signed [SIZE_FILTER_DATA-1:0] event_amp,
    output logic [TS_WIDTH-1:0]                event_ts,
    output logic [7:0]                         event_width,
    output logic [7:0]                         drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RISE    = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam int                            c_HOLD_W    = (HOLDOFF_V_4 > 1) ? $clog2(HOLDOFF_V_4) : 1;
    localparam logic [c_HOLD_W-1:0]           c_HOLD_LAST = c_HOLD_W'(HOLDOFF_V_4 - 1);
    // Levels carried one bit wider so THRESHOLD - HYST cannot overflow.
    localparam logic signed [SIZE_FILTER_DATA:0] c_ARM_LVL = (SIZE_FILTER_DATA+1)'(THRESHOLD_V_4);
    localparam logic signed [SIZE_FILTER_DATA:0] c_END_LVL = (SIZE_FILTER_DATA+1)'(THRESHOLD_V_4 - HYST_V_4);
    localparam logic [7:0]                    c_MIN_W     = 8'(MIN_WIDTH_V_4);

    logic signed [SIZE_FILTER_DATA-1:0] r_sample_q,    w_sample_d;
    logic [TS_WIDTH-1:0]                r_sample_ts_q, w_sample_ts_d;
    logic [TS_WIDTH-1:0]                r_ts_q,        w_ts_d;
    state_t                             r_state_q,     w_state_d;
    logic signed [SIZE_FILTER_DATA-1:0] r_max_q,       w_max_d;
    logic [TS_WIDTH-1:0]                r_ts_max_q,    w_ts_max_d;
    logic [7:0]                         r_width_q,     w_width_d;
    logic [c_HOLD_W-1:0]                r_hold_q,      w_hold_d;
    logic [7:0]                         r_drop_q,      w_drop_d;

    logic signed [SIZE_FILTER_DATA:0]   w_sample_ext;
    logic                               w_above;
    logic                               w_below;
    logic                               w_push;
    logic                               w_full;
    logic                               w_valid;
    peak_event_v_4_t                    w_evt;
    peak_event_v_4_t                    w_head;

    assign w_sample_ext = {r_sample_q[SIZE_FILTER_DATA-1], r_sample_q};
    assign w_above      = (w_sample_ext > c_ARM_LVL);
    assign w_below      = (w_sample_ext < c_END_LVL);

    // Input stage: each sample is tagged with the counter value of the
    // cycle in which it is captured.
    always_comb begin
        w_sample_d    = filter_data;
        w_sample_ts_d = r_ts_q;
        w_ts_d        = r_ts_q + TS_WIDTH'(1);
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_max_d    = r_max_q;
        w_ts_max_d = r_ts_max_q;
        w_width_d  = r_width_q;
        w_hold_d   = r_hold_q;
        w_push     = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_above) begin
                    w_state_d  = ST_RISE;
                    w_max_d    = r_sample_q;
                    w_ts_max_d = r_sample_ts_q;
                    w_width_d  = 8'd1;
                end
            end
            ST_RISE: begin
                if (w_below) begin
                    w_push    = (r_width_q >= c_MIN_W);
                    w_state_d = ST_HOLDOFF;
                    w_hold_d  = '0;
                end else begin
                    // Strict compare keeps the first sample of a flat top.
                    if (r_sample_q > r_max_q) begin
                        w_max_d    = r_sample_q;
                        w_ts_max_d = r_sample_ts_q;
                    end
                    if (r_width_q != 8'hFF) begin
                        w_width_d = r_width_q + 8'd1;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (r_hold_q == c_HOLD_LAST) begin
                    w_state_d = ST_IDLE;
                end else begin
                    w_hold_d = r_hold_q + c_HOLD_W'(1);
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_evt       = '0;
        w_evt.amp   = r_max_q;
        w_evt.ts    = r_ts_max_q;
        w_evt.width = r_width_q;
    end

    // A push is lost only when the queue is full and the head is not leaving.
    always_comb begin
        w_drop_d = r_drop_q;
        if (w_push && w_full && !(w_valid && event_ready) && (r_drop_q != 8'hFF)) begin
            w_drop_d = r_drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sample_q    <= '0;
            r_sample_ts_q <= '0;
            r_ts_q        <= '0;
            r_state_q     <= ST_IDLE;
            r_max_q       <= '0;
            r_ts_max_q    <= '0;
            r_width_q     <= '0;
            r_hold_q      <= '0;
            r_drop_q      <= '0;
        end else begin
            r_sample_q    <= w_sample_d;
            r_sample_ts_q <= w_sample_ts_d;
            r_ts_q        <= w_ts_d;
            r_state_q     <= w_state_d;
            r_max_q       <= w_max_d;
            r_ts_max_q    <= w_ts_max_d;
            r_width_q     <= w_width_d;
            r_hold_q      <= w_hold_d;
            r_drop_q      <= w_drop_d;
        end
    end

    v4_event_fifo2 u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_evt),
        .o_full  (w_full),
        .o_valid (w_valid),
        .i_ready (event_ready),
        .o_data  (w_head)
    );

    assign event_valid = w_valid;
    assign event_amp   = w_head.amp;
    assign event_ts    = w_head.ts;
    assign event_width = w_head.width;
    assign drop_count  = r_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_v4_peak_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_v4_peak_detector
// Description : Self-checking bench for v4_peak_detector. A sample-level
//               pulse model predicts events and drops; predicted events are
//               queued and compared against each event the DUT hands over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_v4_peak_detector;
    import package_settings_v_4::*;

    logic                               clk = 1'b0;
    logic                               reset = 1'b0;
    logic signed [SIZE_FILTER_DATA-1:0] filter_data = '0;
    logic                               event_ready = 1'b0;
    logic                               event_valid;
    logic signed [SIZE_FILTER_DATA-1:0] event_amp;
    logic [TS_WIDTH-1:0]                event_ts;
    logic [7:0]                         event_width;
    logic [7:0]                         drop_count;

    always #5 clk = ~clk;

    v4_peak_detector dut (
        .clk         (clk),
        .reset       (reset),
        .filter_data (filter_data),
        .event_ready (event_ready),
        .event_valid (event_valid),
        .event_amp   (event_amp),
        .event_ts    (event_ts),
        .event_width (event_width),
        .drop_count  (drop_count)
    );

    typedef struct {
        int          amp;
        int unsigned ts;
        int          width;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   ev_count = 0;
    int   last_amp, last_width;
    int unsigned last_ts;

    // Reference model: pulse tracking per sample plus queue occupancy.
    int          m_mode = 0;      // 0 waiting, 1 in pulse, 2 dead time
    int          m_max, m_w, m_dead;
    int unsigned m_ts_max;
    int unsigned m_ts = 0;
    bit          m_pend = 0;
    exp_t        m_pend_evt;
    int          m_cnt = 0;
    int          m_drop = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input int s, input int unsigned ts);
        case (m_mode)
            0: if (s > THRESHOLD_V_4) begin
                   m_mode = 1; m_max = s; m_ts_max = ts; m_w = 1;
               end
            1: if (s < THRESHOLD_V_4 - HYST_V_4) begin
                   if (m_w >= MIN_WIDTH_V_4) begin
                       m_pend = 1;
                       m_pend_evt = '{amp: m_max, ts: m_ts_max, width: m_w};
                   end
                   m_mode = 2; m_dead = HOLDOFF_V_4;
               end else begin
                   if (s > m_max) begin m_max = s; m_ts_max = ts; end
                   if (m_w < 255) m_w++;
               end
            default: begin
                m_dead--;
                if (m_dead == 0) m_mode = 0;
            end
        endcase
    endtask

    // Model of one clock edge given the inputs held across it.
    task automatic model_edge(input int s, input bit rdy, input bit rst_n);
        bit pop;
        if (!rst_n) begin
            m_mode = 0; m_pend = 0; m_cnt = 0; m_drop = 0; m_ts = 0;
            sb_q.delete();
            return;
        end
        pop = (m_cnt > 0) && rdy;
        if (m_pend) begin
            if (m_cnt == 2 && !pop) begin
                if (m_drop < 255) m_drop++;
            end else begin
                sb_q.push_back(m_pend_evt);
                m_cnt++;
            end
            m_pend = 0;
        end
        if (pop) m_cnt--;
        model_step(s, m_ts);
        m_ts++;
    endtask

    task automatic tick(input int s, input bit rdy, input bit rst_n);
        filter_data = 16'(s);
        event_ready = rdy;
        reset       = rst_n;
        @(posedge clk);
        model_edge(s, rdy, rst_n);
        #1;
    endtask

    // rmode: 0 ready low, 1 ready high, 2 random ready
    task automatic pulse(input int peak, input int step, input int flat,
                         input int gap, input int rmode, input int noise);
        int v;
        for (v = 0; v < peak; v += step) tick(v + nz(noise), rdy_of(rmode), 1'b1);
        for (int i = 0; i < flat; i++) tick(peak + nz(noise), rdy_of(rmode), 1'b1);
        for (v = peak - step; v > 0; v -= step) tick(v + nz(noise), rdy_of(rmode), 1'b1);
        for (int i = 0; i < gap; i++) tick(nz(noise), rdy_of(rmode), 1'b1);
    endtask

    function automatic bit rdy_of(input int rmode);
        if (rmode == 2) return ($urandom_range(0, 9) < 7);
        return (rmode == 1);
    endfunction

    function automatic int nz(input int noise);
        if (noise == 0) return 0;
        return int'($urandom_range(0, 2 * noise)) - noise;
    endfunction

    task automatic drain();
        for (int i = 0; i < 12; i++) tick(0, 1'b1, 1'b1);
    endtask

    // Monitor: compares each handed-over event with the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1) begin
            chk("drop_count", drop_count, m_drop);
            if (event_valid && event_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_event_queue_depth", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("event_amp", $signed(event_amp), e.amp);
                    chk("event_ts", event_ts, e.ts);
                    chk("event_width", event_width, e.width);
                    ev_count++;
                    last_amp   = $signed(event_amp);
                    last_ts    = event_ts;
                    last_width = event_width;
                end
            end
        end
    end

    initial begin
        int base;
        int t2 [5];
        t2 = '{100, 210, 250, 220, 100};

        // Reset state
        tick(0, 1'b0, 1'b0);
        tick(0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_valid", event_valid, 0);
        chk("rst_amp", event_amp, 0);
        chk("rst_ts", event_ts, 0);
        chk("rst_width", event_width, 0);
        chk("rst_drop", drop_count, 0);
        @(posedge clk); #1;

        // 1: trapezoid to 1000, 20-sample flat top; first 1000 sample at ts 100
        base = ev_count;
        pulse(1000, 10, 20, 12, 1, 0);
        chk("t1_events", ev_count - base, 1);
        chk("t1_amp", last_amp, 1000);
        chk("t1_ts", last_ts, 100);
        chk("t1_width", last_width, 180);

        // 2: only three samples above threshold
        base = ev_count;
        for (int i = 0; i < 5; i++) tick(t2[i], 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) tick(0, 1'b1, 1'b1);
        chk("t2_events", ev_count - base, 0);
        chk("t2_valid", event_valid, 0);

        // 3: chatter inside the hysteresis band is one pulse
        base = ev_count;
        tick(205, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) tick((i % 2) ? 195 : 205, 1'b1, 1'b1);
        tick(190, 1'b1, 1'b1);
        tick(185, 1'b1, 1'b1);
        tick(184, 1'b1, 1'b1);
        tick(183, 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) tick(0, 1'b1, 1'b1);
        chk("t3_events", ev_count - base, 1);
        chk("t3_amp", last_amp, 205);
        chk("t3_width", last_width, 24);

        // 4: three pulses with consumer stalled
        base = ev_count;
        for (int p = 0; p < 3; p++) pulse(500 + 100 * p, 100, 2, 12, 0, 0);
        chk("t4_valid", event_valid, 1);
        chk("t4_drop", drop_count, 1);
        drain();
        chk("t4_events", ev_count - base, 2);
        chk("t4_last_amp", last_amp, 600);

        // 5: second pulse starts inside the dead time
        base = ev_count;
        pulse(500, 100, 2, 3, 1, 0);
        for (int i = 0; i < 15; i++) tick(600, 1'b1, 1'b1);
        drain();
        chk("t5_events", ev_count - base, 2);
        chk("t5_width", last_width, 10);

        // 6: reset mid-pulse and with a full queue
        tick(300, 1'b1, 1'b1);
        tick(400, 1'b1, 1'b1);
        tick(0, 1'b1, 1'b0);
        for (int p = 0; p < 3; p++) pulse(500, 100, 2, 12, 0, 0);
        tick(0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_valid", event_valid, 0);
        chk("t6_drop", drop_count, 0);
        @(posedge clk); #1;
        base = ev_count;
        pulse(500, 100, 2, 12, 1, 0);
        chk("t6_events", ev_count - base, 1);
        chk("t6_ts", last_ts, 5);

        // Randomized pulses, noise and consumer stalls
        for (int p = 0; p < 40; p++) begin
            pulse(int'($urandom_range(150, 3000)), int'($urandom_range(20, 300)),
                  int'($urandom_range(0, 10)), int'($urandom_range(0, 15)), 2,
                  int'($urandom_range(0, 8)));
        end
        drain();
        chk("final_pending", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
